vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// Parametrised VGA raster timing generator; successor to the fixed 800x525 counter block.
// Derives a pixel strobe from Clk and runs programmable H/V counters (active, front porch, sync, back porch).
// Emits sync polarity per mode, blanking, pixel coordinates for VRAM addressing and frame/line start pulses.
// Sync/blank outputs are delayed by a programmable number of pixel periods to match VRAM read latency.
// Sits between the system clock and the VRAM-to-DAC bridge.
// PARAMETERS
// CLK_DIV  2   Clk cycles per pixel; even, >=2.
// H_ACT    640 visible pixels per line.
// H_FP     16  horizontal front porch, in pixels.
// H_SYNC   96  horizontal sync width, in pixels.
// H_BP     48  horizontal back porch, in pixels.
// V_ACT    480 visible lines.
// V_FP     10  vertical front porch, in lines.
// V_SYNC   2   vertical sync width, in lines.
// V_BP     33  vertical back porch, in lines.
// H_POL    0   Hsync active level (0 = active-low).
// V_POL    0   Vsync active level (0 = active-low).
// PIPE_DLY 1   pixel periods of delay on Hsync/Vsync/VGA_blank/Active; 0..7.
// PORTS
// Clk        in  1   system clock; the single clock of the block.
// Rst        in  1   asynchronous reset, active-high.
// En         in  1   run enable; low holds the raster at the origin.
// VGA_Clk    out 1   pixel clock to DAC: high while div_cnt >= CLK_DIV/2.
// PixEn      out 1   one-Clk strobe per pixel; high when div_cnt == CLK_DIV-1.
// PixX       out 11  current H count, 0..H_TOTAL-1 (undelayed).
// PixY       out 11  current V count, 0..V_TOTAL-1 (undelayed).
// Active     out 1   delayed (PixX<H_ACT && PixY<V_ACT).
// Hsync      out 1   delayed horizontal sync.
// Vsync      out 1   delayed vertical sync.
// VGA_blank  out 1   DAC blank_n = Active.
// VGA_sync   out 1   constant 0 (no sync-on-green).
// LineStart  out 1   one-PixEn-period pulse when PixX==0.
// FrameStart out 1   one-PixEn-period pulse when PixX==0 && PixY==0.
// BEHAVIOUR
// - H_TOTAL = H_ACT+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be <=2048 (elaboration assert).
// - Reset (async): div_cnt=0, PixX=0, PixY=0, VGA_Clk=0, PixEn=0, Active=0, VGA_blank=0.
//   Also on reset: Hsync=~H_POL, Vsync=~V_POL, LineStart=0, FrameStart=0; delay line filled with inactive values.
// - div_cnt: 0..CLK_DIV-1, increments every Clk while En=1 and wraps to 0.
// - On PixEn: PixX increments. At PixX==H_TOTAL-1, PixX->0 and PixY increments.
//   At PixY==V_TOTAL-1 with the H wrap, PixY->0.
// - Hsync active iff H_ACT+H_FP <= PixX < H_ACT+H_FP+H_SYNC.
//   Vsync active iff V_ACT+V_FP <= PixY < V_ACT+V_FP+V_SYNC. Both are decoded from the undelayed counters.
// - Active/Hsync/Vsync pass through a PIPE_DLY-stage shift register clocked on PixEn.
//   PIPE_DLY=0: registered once on Clk, with no extra pixel delay.
// - LineStart/FrameStart: undelayed, registered; high for exactly CLK_DIV Clk cycles.
// - En falls: synchronously clear div_cnt, PixX, PixY and the delay line (inactive values).
//   All outputs then equal their reset values. En rising restarts at (0,0) with FrameStart.
// - Rst mid-frame: immediate return to reset state. No partial-line recovery.
// STRUCTURE
// - vga_pkg: localparam bundles for 640x480@60 and 800x600@60, plus a function computing the totals.
// - Sub-module vga_delay_line #(W,DEPTH): PixEn-qualified shift register with async reset value input.
// TESTING
// 1. Default params, Rst 5 cycles then En=1 -> Hsync low for 192 Clk every 1600 Clk.
//    Also: Vsync low for 2 lines every 525 lines; FrameStart period = 840000 Clk.
// 2. Check Hsync falling edge and PixY -> Hsync falls 2*(640+16+PIPE_DLY) Clk after LineStart;
//    PixY reaches 524 then 0.
// 3. Check Active -> VGA_blank high exactly 640 pixels per line and only on lines 0..479.
// 4. H_POL=1,V_POL=1, CLK_DIV=4 -> syncs active-high; PixEn every 4 Clk; VGA_Clk 2 high/2 low.
// 5. En dropped at PixX=300,PixY=200 -> next Clk counters 0, Hsync/Vsync inactive.
//    Re-enable -> FrameStart on first pixel.
// 6. Rst asserted mid-line, asynchronously between edges -> outputs at reset values before the next Clk edge.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared mode bundles, widths and helpers for the VGA raster generator
package vga_pkg;

  localparam int COORD_W   = 11;
  localparam int MAX_TOTAL = 2048;

  // One axis of a video mode: visible span, porches, sync width and sync level.
  typedef struct packed {
    logic [COORD_W-1:0] act;
    logic [COORD_W-1:0] fp;
    logic [COORD_W-1:0] sync;
    logic [COORD_W-1:0] bp;
    logic               pol;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } mode_timing_t;

  // Raster signals that travel through the VRAM-latency delay line, stored at pin polarity.
  typedef struct packed {
    logic vs;
    logic hs;
    logic act;
  } raster_sig_t;

  localparam mode_timing_t MODE_640X480_60 = '{
    h: '{act: 11'd640, fp: 11'd16, sync: 11'd96,  bp: 11'd48, pol: 1'b0},
    v: '{act: 11'd480, fp: 11'd10, sync: 11'd2,   bp: 11'd33, pol: 1'b0}
  };

  localparam mode_timing_t MODE_800X600_60 = '{
    h: '{act: 11'd800, fp: 11'd40, sync: 11'd128, bp: 11'd88, pol: 1'b1},
    v: '{act: 11'd600, fp: 11'd1,  sync: 11'd4,   bp: 11'd23, pol: 1'b1}
  };

  // Total period of one axis in pixels or lines.
  function automatic int calc_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - pixel-strobe qualified shift register with clear and reset fill value
module vga_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic         clr,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, rst_val, clr, shift_en};
    assign dout        = din;
  end else begin : g_shift
    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    // Clear to the idle pattern, otherwise advance one stage per pixel strobe.
    always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i];
      end
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_d[i] = rst_val;
        end
      end else if (shift_en) begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    // Stage registers, filled with the idle pattern on reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= rst_val;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with latency-matched syncs
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIPE_DLY = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               En,
  output logic               VGA_Clk,
  output logic               PixEn,
  output logic [COORD_W-1:0] PixX,
  output logic [COORD_W-1:0] PixY,
  output logic               Active,
  output logic               Hsync,
  output logic               Vsync,
  output logic               VGA_blank,
  output logic               VGA_sync,
  output logic               LineStart,
  output logic               FrameStart
);

  localparam int H_TOTAL = calc_total(H_ACT, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACT, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CMP_W   = COORD_W + 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);

  // Decode thresholds are one bit wider so a 2048 total cannot alias to zero.
  localparam logic [CMP_W-1:0] H_ACT_C  = CMP_W'(H_ACT);
  localparam logic [CMP_W-1:0] HS_BEG_C = CMP_W'(H_ACT + H_FP);
  localparam logic [CMP_W-1:0] HS_END_C = CMP_W'(H_ACT + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] V_ACT_C  = CMP_W'(V_ACT);
  localparam logic [CMP_W-1:0] VS_BEG_C = CMP_W'(V_ACT + V_FP);
  localparam logic [CMP_W-1:0] VS_END_C = CMP_W'(V_ACT + V_FP + V_SYNC);

  localparam raster_sig_t SIG_IDLE = '{vs: ~V_POL, hs: ~H_POL, act: 1'b0};

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
  end
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be even and at least 2");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be in 0..7");
  end

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d;
  logic [COORD_W-1:0] pix_y_q, pix_y_d;
  logic               vga_clk_q, vga_clk_d;
  logic               pix_en_q, pix_en_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  raster_sig_t        raw_q, raw_d;
  raster_sig_t        dly_out;
  logic               pix_tick;
  logic [CMP_W-1:0]   x_ext, y_ext;

  // The counter update that closes a pixel period happens on the same edge as the strobe.
  assign pix_tick = (div_cnt_q == DIV_LAST);

  // Divider and raster counters; dropping En parks everything at the origin.
  always_comb begin
    div_cnt_d = div_cnt_q;
    pix_x_d   = pix_x_q;
    pix_y_d   = pix_y_q;
    if (!En) begin
      div_cnt_d = '0;
      pix_x_d   = '0;
      pix_y_d   = '0;
    end else begin
      div_cnt_d = pix_tick ? '0 : div_cnt_q + DIV_W'(1);
      if (pix_tick) begin
        if (pix_x_q == H_LAST) begin
          pix_x_d = '0;
          pix_y_d = (pix_y_q == V_LAST) ? '0 : pix_y_q + COORD_W'(1);
        end else begin
          pix_x_d = pix_x_q + COORD_W'(1);
        end
      end
    end
  end

  assign x_ext = {1'b0, pix_x_d};
  assign y_ext = {1'b0, pix_y_d};

  // Decode from next-state counters so registered strobes and syncs line up with PixX/PixY.
  always_comb begin
    vga_clk_d     = (div_cnt_d >= DIV_HALF);
    pix_en_d      = (div_cnt_d == DIV_LAST);
    line_start_d  = En && (pix_x_d == '0);
    frame_start_d = line_start_d && (pix_y_d == '0);
    raw_d         = SIG_IDLE;
    if (En) begin
      raw_d.act = (x_ext < H_ACT_C) && (y_ext < V_ACT_C);
      raw_d.hs  = ((x_ext >= HS_BEG_C) && (x_ext < HS_END_C)) ? H_POL : ~H_POL;
      raw_d.vs  = ((y_ext >= VS_BEG_C) && (y_ext < VS_END_C)) ? V_POL : ~V_POL;
    end
  end

  // Raster state and undelayed registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      div_cnt_q     <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      vga_clk_q     <= 1'b0;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      raw_q         <= SIG_IDLE;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      vga_clk_q     <= vga_clk_d;
      pix_en_q      <= pix_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      raw_q         <= raw_d;
    end
  end

  vga_delay_line #(
    .W     ($bits(raster_sig_t)),
    .DEPTH (PIPE_DLY)
  ) u_delay (
    .clk      (Clk),
    .rst      (Rst),
    .rst_val  (SIG_IDLE),
    .clr      (!En),
    .shift_en (En && pix_tick),
    .din      (raw_q),
    .dout     (dly_out)
  );

  assign VGA_Clk    = vga_clk_q;
  assign PixEn      = pix_en_q;
  assign PixX       = pix_x_q;
  assign PixY       = pix_y_q;
  assign LineStart  = line_start_q;
  assign FrameStart = frame_start_q;
  assign Active     = dly_out.act;
  assign Hsync      = dly_out.hs;
  assign Vsync      = dly_out.vs;
  assign VGA_blank  = dly_out.act;
  assign VGA_sync   = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  // Instance A: active-low syncs, two-pixel latency. Instance B: active-high, CLK_DIV=4, no latency.
  localparam int D_A = 2, HA_A = 20, HF_A = 4, HS_A = 6, HB_A = 5, VA_A = 8, VF_A = 2, VS_A = 2, VB_A = 3, PD_A = 2;
  localparam int D_B = 4, HA_B = 10, HF_B = 2, HS_B = 3, HB_B = 2, VA_B = 4, VF_B = 1, VS_B = 1, VB_B = 2, PD_B = 0;
  localparam int HT_A = 35, VT_A = 15, FRAME_A = 1050;

  typedef struct packed {
    logic        vclk;
    logic        pixen;
    logic [10:0] x;
    logic [10:0] y;
    logic        act;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        sync_g;
    logic        ls;
    logic        fs;
  } obs_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic En  = 1'b0;

  logic        a_vclk, a_pixen, a_act, a_hs, a_vs, a_blank, a_sync, a_ls, a_fs;
  logic [10:0] a_x, a_y;
  logic        b_vclk, b_pixen, b_act, b_hs, b_vs, b_blank, b_sync, b_ls, b_fs;
  logic [10:0] b_x, b_y;
  obs_t        obs_a, obs_b;

  int     errors = 0;
  int     checks = 0;
  longint n = 0;

  always #5 Clk = ~Clk;

  vga_timing_gen #(
    .CLK_DIV(D_A), .H_ACT(HA_A), .H_FP(HF_A), .H_SYNC(HS_A), .H_BP(HB_A),
    .V_ACT(VA_A), .V_FP(VF_A), .V_SYNC(VS_A), .V_BP(VB_A),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE_DLY(PD_A)
  ) u_dut_a (
    .Clk(Clk), .Rst(Rst), .En(En), .VGA_Clk(a_vclk), .PixEn(a_pixen), .PixX(a_x), .PixY(a_y),
    .Active(a_act), .Hsync(a_hs), .Vsync(a_vs), .VGA_blank(a_blank), .VGA_sync(a_sync),
    .LineStart(a_ls), .FrameStart(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(D_B), .H_ACT(HA_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
    .V_ACT(VA_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B),
    .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(PD_B)
  ) u_dut_b (
    .Clk(Clk), .Rst(Rst), .En(En), .VGA_Clk(b_vclk), .PixEn(b_pixen), .PixX(b_x), .PixY(b_y),
    .Active(b_act), .Hsync(b_hs), .Vsync(b_vs), .VGA_blank(b_blank), .VGA_sync(b_sync),
    .LineStart(b_ls), .FrameStart(b_fs)
  );

  assign obs_a = {a_vclk, a_pixen, a_x, a_y, a_act, a_hs, a_vs, a_blank, a_sync, a_ls, a_fs};
  assign obs_b = {b_vclk, b_pixen, b_x, b_y, b_act, b_hs, b_vs, b_blank, b_sync, b_ls, b_fs};

  // Number of enabled Clk edges since the raster last left the origin.
  always @(posedge Clk or posedge Rst) begin
    if (Rst)     n <= 0;
    else if (En) n <= n + 1;
    else         n <= 0;
  end

  // Expected outputs after n enabled edges: pixel index is n/D, syncs lag by pd pixels.
  function automatic obs_t model(input longint cnt, input int d, input int ha, input int hf, input int hs,
                                 input int hb, input int va, input int vf, input int vs, input int vb,
                                 input bit hp, input bit vp, input int pd);
    obs_t   o;
    longint ht, vt, dv, p, q, qx, qy;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    o    = '0;
    o.hs = ~hp;
    o.vs = ~vp;
    if (cnt == 0) return o;
    dv      = cnt % d;
    p       = cnt / d;
    o.vclk  = (dv >= d / 2);
    o.pixen = (dv == d - 1);
    o.x     = 11'(p % ht);
    o.y     = 11'((p / ht) % vt);
    o.ls    = (o.x == 0);
    o.fs    = o.ls && (o.y == 0);
    q       = p - pd;
    if (q >= 0) begin
      qx    = q % ht;
      qy    = (q / ht) % vt;
      o.act = (qx < ha) && (qy < va);
      o.hs  = (qx >= ha + hf && qx < ha + hf + hs) ? hp : ~hp;
      o.vs  = (qy >= va + vf && qy < va + vf + vs) ? vp : ~vp;
    end
    o.blank = o.act;
    return o;
  endfunction

  function automatic obs_t exp_a(input longint cnt);
    return model(cnt, D_A, HA_A, HF_A, HS_A, HB_A, VA_A, VF_A, VS_A, VB_A, 1'b0, 1'b0, PD_A);
  endfunction

  function automatic obs_t exp_b(input longint cnt);
    return model(cnt, D_B, HA_B, HF_B, HS_B, HB_B, VA_B, VF_B, VS_B, VB_B, 1'b1, 1'b1, PD_B);
  endfunction

  task automatic test_reset();
    Rst = 1'b1;
    En  = 1'b0;
    repeat (5) @(negedge Clk);
    checks += 4;
    if (obs_a !== exp_a(0)) begin errors++; $display("FAIL reset_a got=%h exp=%h", obs_a, exp_a(0)); end
    if (obs_b !== exp_b(0)) begin errors++; $display("FAIL reset_b got=%h exp=%h", obs_b, exp_b(0)); end
    if (a_hs !== 1'b1 || a_vs !== 1'b1) begin errors++; $display("FAIL reset_a_sync got=%b%b exp=11", a_hs, a_vs); end
    if (b_hs !== 1'b0 || b_vs !== 1'b0) begin errors++; $display("FAIL reset_b_sync got=%b%b exp=00", b_hs, b_vs); end
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (obs_a !== exp_a(0)) begin errors++; $display("FAIL idle_a got=%h exp=%h", obs_a, exp_a(0)); end
  endtask

  task automatic test_raster();
    int   hs_run = 0, vs_run = 0, act_run = 0, bhs_run = 0, ls_c = -1, fs_c = -1, fs_cnt = 0, pe_c = -1;
    int   max_y = 0;
    bit   wrap_seen = 1'b0;
    logic p_hs = 1'b1, p_vs = 1'b1, p_act = 1'b0, p_ls = 1'b0, p_fs = 1'b0, p_bhs = 1'b0;
    logic [10:0] p_y = '0;
    En = 1'b1;
    for (int c = 0; c < 2200; c++) begin
      @(negedge Clk);
      checks += 2;
      if (obs_a !== exp_a(n)) begin errors++; $display("FAIL raster_a n=%0d got=%h exp=%h", n, obs_a, exp_a(n)); end
      if (obs_b !== exp_b(n)) begin errors++; $display("FAIL raster_b n=%0d got=%h exp=%h", n, obs_b, exp_b(n)); end
      if (a_ls === 1'b1 && p_ls === 1'b0) ls_c = c;
      if (a_hs === 1'b0 && p_hs === 1'b1 && ls_c > 0) begin
        checks++;
        if (c - ls_c !== D_A * (HA_A + HF_A + PD_A)) begin
          errors++; $display("FAIL hs_fall_after_ls got=%0d exp=%0d", c - ls_c, D_A * (HA_A + HF_A + PD_A));
        end
      end
      if (a_hs === 1'b0) hs_run++;
      else if (p_hs === 1'b0) begin
        checks++;
        if (hs_run !== D_A * HS_A) begin errors++; $display("FAIL hs_width got=%0d exp=%0d", hs_run, D_A * HS_A); end
        hs_run = 0;
      end
      if (a_vs === 1'b0) vs_run++;
      else if (p_vs === 1'b0) begin
        checks++;
        if (vs_run !== D_A * HT_A * VS_A) begin errors++; $display("FAIL vs_width got=%0d exp=%0d", vs_run, D_A * HT_A * VS_A); end
        vs_run = 0;
      end
      if (a_blank === 1'b1) act_run++;
      else if (p_act === 1'b1) begin
        checks++;
        if (act_run !== D_A * HA_A) begin errors++; $display("FAIL blank_width got=%0d exp=%0d", act_run, D_A * HA_A); end
        act_run = 0;
      end
      if (a_fs === 1'b1 && p_fs === 1'b0) begin
        fs_cnt++;
        if (fs_cnt >= 3) begin
          checks++;
          if (c - fs_c !== FRAME_A) begin errors++; $display("FAIL frame_period got=%0d exp=%0d", c - fs_c, FRAME_A); end
        end
        fs_c = c;
      end
      if (b_pixen === 1'b1) begin
        if (pe_c >= 0) begin
          checks++;
          if (c - pe_c !== D_B) begin errors++; $display("FAIL b_pixen_period got=%0d exp=%0d", c - pe_c, D_B); end
        end
        pe_c = c;
      end
      if (b_hs === 1'b1) bhs_run++;
      else if (p_bhs === 1'b1) begin
        checks++;
        if (bhs_run !== D_B * HS_B) begin errors++; $display("FAIL b_hs_width got=%0d exp=%0d", bhs_run, D_B * HS_B); end
        bhs_run = 0;
      end
      if (int'(a_y) > max_y) max_y = int'(a_y);
      if (p_y == 11'(VT_A - 1) && a_y == 11'd0) wrap_seen = 1'b1;
      p_hs = a_hs; p_vs = a_vs; p_act = a_blank; p_ls = a_ls; p_fs = a_fs; p_bhs = b_hs; p_y = a_y;
    end
    checks++;
    if (max_y !== VT_A - 1 || !wrap_seen) begin
      errors++; $display("FAIL pixy_wrap got max=%0d wrap=%0d exp max=%0d wrap=1", max_y, wrap_seen, VT_A - 1);
    end
  endtask

  task automatic test_en_drop();
    int tx, ty, hold;
    bit hit;
    for (int k = 0; k < 3; k++) begin
      tx  = int'($urandom_range(1, HT_A - 1));
      ty  = int'($urandom_range(0, VT_A - 1));
      hit = 1'b0;
      for (int c = 0; c < 2 * FRAME_A && !hit; c++) begin
        @(negedge Clk);
        checks += 2;
        if (obs_a !== exp_a(n)) begin errors++; $display("FAIL drop_run_a n=%0d got=%h exp=%h", n, obs_a, exp_a(n)); end
        if (obs_b !== exp_b(n)) begin errors++; $display("FAIL drop_run_b n=%0d got=%h exp=%h", n, obs_b, exp_b(n)); end
        if (int'(a_x) == tx && int'(a_y) == ty) hit = 1'b1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL drop_target_timeout got=none exp=(%0d,%0d)", tx, ty); end
      En = 1'b0;
      @(negedge Clk);
      checks += 3;
      if (a_x !== 11'd0 || a_y !== 11'd0) begin errors++; $display("FAIL drop_counters got=(%0d,%0d) exp=(0,0)", a_x, a_y); end
      if (a_hs !== 1'b1 || a_vs !== 1'b1 || a_act !== 1'b0) begin
        errors++; $display("FAIL drop_a_idle got=%b%b%b exp=110", a_hs, a_vs, a_act);
      end
      if (b_hs !== 1'b0 || b_vs !== 1'b0 || b_act !== 1'b0) begin
        errors++; $display("FAIL drop_b_idle got=%b%b%b exp=000", b_hs, b_vs, b_act);
      end
      hold = int'($urandom_range(1, 5));
      repeat (hold) begin
        @(negedge Clk);
        checks++;
        if (obs_a !== exp_a(0)) begin errors++; $display("FAIL drop_hold_a got=%h exp=%h", obs_a, exp_a(0)); end
      end
      En = 1'b1;
      @(negedge Clk);
      checks += 2;
      if (a_fs !== 1'b1 || a_ls !== 1'b1 || a_x !== 11'd0 || a_y !== 11'd0) begin
        errors++; $display("FAIL restart_a got fs=%b ls=%b x=%0d y=%0d exp fs=1 ls=1 x=0 y=0", a_fs, a_ls, a_x, a_y);
      end
      if (b_fs !== 1'b1 || b_x !== 11'd0 || b_y !== 11'd0) begin
        errors++; $display("FAIL restart_b got fs=%b x=%0d y=%0d exp fs=1 x=0 y=0", b_fs, b_x, b_y);
      end
    end
  endtask

  task automatic test_async_reset();
    int run;
    for (int k = 0; k < 2; k++) begin
      run = int'($urandom_range(100, 900));
      for (int c = 0; c < run; c++) begin
        @(negedge Clk);
        checks += 2;
        if (obs_a !== exp_a(n)) begin errors++; $display("FAIL prerst_a n=%0d got=%h exp=%h", n, obs_a, exp_a(n)); end
        if (obs_b !== exp_b(n)) begin errors++; $display("FAIL prerst_b n=%0d got=%h exp=%h", n, obs_b, exp_b(n)); end
      end
      #($urandom_range(1, 3));
      Rst = 1'b1;
      #1;
      checks += 2;
      if (obs_a !== exp_a(0)) begin errors++; $display("FAIL async_rst_a got=%h exp=%h", obs_a, exp_a(0)); end
      if (obs_b !== exp_b(0)) begin errors++; $display("FAIL async_rst_b got=%h exp=%h", obs_b, exp_b(0)); end
      @(negedge Clk);
      Rst = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge Clk);
        checks += 2;
        if (obs_a !== exp_a(n)) begin errors++; $display("FAIL postrst_a n=%0d got=%h exp=%h", n, obs_a, exp_a(n)); end
        if (obs_b !== exp_b(n)) begin errors++; $display("FAIL postrst_b n=%0d got=%h exp=%h", n, obs_b, exp_b(n)); end
      end
    end
  endtask

  task automatic test_random_en();
    for (int c = 0; c < 1500; c++) begin
      @(negedge Clk);
      checks += 2;
      if (obs_a !== exp_a(n)) begin errors++; $display("FAIL rand_en_a n=%0d got=%h exp=%h", n, obs_a, exp_a(n)); end
      if (obs_b !== exp_b(n)) begin errors++; $display("FAIL rand_en_b n=%0d got=%h exp=%h", n, obs_b, exp_b(n)); end
      if ($urandom_range(0, 99) < 2) En = ~En;
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_en_drop();
    test_async_reset();
    test_random_en();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
